// File: rtl/bch_pkg.sv
// Shared constants and types for the BCH(63,51) encode/serialize path.
package bch_pkg;

  localparam int          CW_LEN    = 63;
  localparam int          MSG_LEN   = 51;
  localparam int          PAR_LEN   = 12;
  localparam int          SYNC_LEN  = 16;
  localparam logic [15:0] SYNC_WORD = 16'hEB90;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } ser_state_t;

endpackage

// File: rtl/bch_frame_serializer.sv
// Double-buffered codeword-to-serial framer: sync header then codeword, MSB first,
// over a valid/ready bit stream. All outputs come straight from registers.
module bch_frame_serializer
  import bch_pkg::ser_state_t;
  import bch_pkg::IDLE;
  import bch_pkg::SYNC;
  import bch_pkg::DATA;
#(
  parameter int                  CW_LEN    = bch_pkg::CW_LEN,
  parameter int                  SYNC_LEN  = bch_pkg::SYNC_LEN,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = bch_pkg::SYNC_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CW_LEN-1:0] cw_in,
  input  logic              cw_valid,
  output logic              cw_ready,
  output logic              bit_out,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic              frame_start,
  output logic              frame_end
);

  localparam int         SI_W      = $clog2(SYNC_LEN);
  localparam int         DI_W      = $clog2(CW_LEN);
  localparam logic [6:0] SYNC_LAST = 7'(SYNC_LEN - 1);
  localparam logic [6:0] DATA_LAST = 7'(CW_LEN - 1);

  ser_state_t        r_state, w_state_nxt;
  logic [6:0]        r_cnt, w_cnt_nxt;
  logic [CW_LEN-1:0] r_shreg, w_shreg_nxt;
  logic [CW_LEN-1:0] r_hold, w_hold_nxt;
  logic              r_hold_full, w_hold_full_nxt;
  logic              r_cw_ready, r_bit_out, r_bit_valid, r_frame_start, r_frame_end;
  logic              w_accept, w_xfer, w_last_sync, w_last_data;
  logic [SI_W-1:0]   w_sync_idx;
  logic [DI_W-1:0]   w_data_idx;
  logic              w_bit_nxt;

  assign w_accept    = cw_valid & r_cw_ready;
  assign w_xfer      = r_bit_valid & bit_ready;
  assign w_last_sync = w_xfer & (r_cnt == SYNC_LAST);
  assign w_last_data = w_xfer & (r_cnt == DATA_LAST);

  // Next-state: FSM, bit counter, active frame register and holding register.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_shreg_nxt     = r_shreg;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_shreg_nxt = cw_in;
          w_state_nxt = SYNC;
          w_cnt_nxt   = 7'd0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SYNC: begin
        if (w_accept) begin
          w_hold_nxt      = cw_in;
          w_hold_full_nxt = 1'b1;
        end else begin
          w_hold_full_nxt = r_hold_full;
        end
        if (w_last_sync) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = 7'd0;
        end else if (w_xfer) begin
          w_cnt_nxt = r_cnt + 7'd1;
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      DATA: begin
        // hold_full forces cw_ready low, so a hold hand-off never races a new accept.
        if (w_last_data) begin
          w_cnt_nxt = 7'd0;
          if (r_hold_full) begin
            w_shreg_nxt     = r_hold;
            w_hold_full_nxt = 1'b0;
            w_state_nxt     = SYNC;
          end else if (w_accept) begin
            w_shreg_nxt = cw_in;
            w_state_nxt = SYNC;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          if (w_accept) begin
            w_hold_nxt      = cw_in;
            w_hold_full_nxt = 1'b1;
          end else begin
            w_hold_full_nxt = r_hold_full;
          end
          if (w_xfer) begin
            w_cnt_nxt = r_cnt + 7'd1;
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_cnt_nxt       = 7'd0;
        w_hold_full_nxt = 1'b0;
      end
    endcase
  end

  // Serial bit for the upcoming state, so the output can be registered.
  always_comb begin
    w_sync_idx = SI_W'(SYNC_LAST - w_cnt_nxt);
    w_data_idx = DI_W'(DATA_LAST - w_cnt_nxt);
    case (w_state_nxt)
      SYNC:    w_bit_nxt = SYNC_WORD[w_sync_idx];
      DATA:    w_bit_nxt = w_shreg_nxt[w_data_idx];
      default: w_bit_nxt = 1'b0;
    endcase
  end

  // State and output registers; reset discards both the active frame and hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= 7'd0;
      r_shreg       <= '0;
      r_hold        <= '0;
      r_hold_full   <= 1'b0;
      r_cw_ready    <= 1'b1;
      r_bit_out     <= 1'b0;
      r_bit_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_shreg       <= w_shreg_nxt;
      r_hold        <= w_hold_nxt;
      r_hold_full   <= w_hold_full_nxt;
      r_cw_ready    <= ~w_hold_full_nxt;
      r_bit_out     <= w_bit_nxt;
      r_bit_valid   <= (w_state_nxt != IDLE);
      r_frame_start <= (w_state_nxt == SYNC) && (w_cnt_nxt == 7'd0);
      r_frame_end   <= (w_state_nxt == DATA) && (w_cnt_nxt == DATA_LAST);
    end
  end

  assign cw_ready    = r_cw_ready;
  assign bit_out     = r_bit_out;
  assign bit_valid   = r_bit_valid;
  assign frame_start = r_frame_start;
  assign frame_end   = r_frame_end;

endmodule

// File: tb/tb_bch_frame_serializer.sv
// Directed bench for bch_frame_serializer: framing, back-to-back, backpressure,
// frame-end boundary, mid-frame reset and full-buffer behaviour.
module tb_bch_frame_serializer;

  localparam logic [15:0] SW = 16'hEB90;

  logic        clk = 1'b0;
  logic        rst, cw_valid, bit_ready;
  logic [62:0] cw_in;
  logic        cw_ready, bit_out, bit_valid, frame_start, frame_end;

  always #5 clk = ~clk;

  bch_frame_serializer dut (
    .clk         (clk),
    .rst         (rst),
    .cw_in       (cw_in),
    .cw_valid    (cw_valid),
    .cw_ready    (cw_ready),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .bit_ready   (bit_ready),
    .frame_start (frame_start),
    .frame_end   (frame_end)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [62:0] feed[$];
  int          feed_at[$];
  int          acc_cyc[$];
  logic [62:0] kept[$];
  logic [157:0] got;
  int          n_got, gaps, flag_err, stall_err, ready_low, first_valid;

  localparam logic [62:0] CW_A = 63'h2AAA_AAAA_AAAA_AAAA;
  localparam logic [62:0] CW_B = 63'h7FFF_FFFF_FFFF_F000;
  localparam logic [62:0] CW_C = 63'h0000_0000_0000_0FFF;
  localparam logic [62:0] CW_D = 63'h5A5A_1234_0F0F_C3C3;
  localparam logic [62:0] CW_E = 63'h4C3B_2A19_0817_F6E5;
  localparam logic [62:0] CW_F = 63'h1111_2222_4444_8888;
  localparam logic [62:0] CW_G = 63'h6DB6_DB6D_B6DB_6DB6;
  localparam logic [62:0] CW_H = 63'h0123_4567_89AB_CDEF;
  localparam logic [62:0] CW_J = 63'h3C3C_5A5A_9696_A5A5;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives feed/bit_ready each negedge and collects nwant transferred bits.
  task automatic run(input int nwant, input int stall_at, input bit rnd);
    int   cyc;
    int   stall_left;
    bit   br, prev_stall;
    logic pv, pb, ps, pe;
    cyc = 0; stall_left = 10; prev_stall = 1'b0;
    pv = 1'b0; pb = 1'b0; ps = 1'b0; pe = 1'b0;
    got = '0; n_got = 0; gaps = 0; flag_err = 0; stall_err = 0;
    ready_low = 0; first_valid = -1;
    acc_cyc.delete();
    while (n_got < nwant && cyc < 3000) begin
      if (prev_stall && ({bit_valid, bit_out, frame_start, frame_end} !== {pv, pb, ps, pe}))
        stall_err++;
      if (cw_ready !== 1'b1) ready_low++;
      if (feed.size() > 0 && cyc >= feed_at[0]) begin
        cw_valid = 1'b1;
        cw_in    = feed[0];
        if (cw_ready === 1'b1) begin
          acc_cyc.push_back(cyc);
          feed.delete(0);
          feed_at.delete(0);
        end
      end else begin
        cw_valid = 1'b0;
      end
      if (n_got == stall_at && stall_left > 0) begin
        br = 1'b0;
        stall_left--;
      end else if (rnd && stall_at >= 0 && n_got > stall_at) begin
        br = 1'($urandom_range(0, 1));
      end else begin
        br = 1'b1;
      end
      bit_ready = br;
      if (bit_valid === 1'b1) begin
        if (first_valid < 0) first_valid = cyc;
        if (frame_start !== ((n_got % 79) == 0) || frame_end !== ((n_got % 79) == 78))
          flag_err++;
        if (br) begin
          got = {got[156:0], bit_out};
          n_got++;
        end
      end else if (n_got > 0) begin
        gaps++;
      end
      prev_stall = (bit_valid === 1'b1) && !br;
      pv = bit_valid; pb = bit_out; ps = frame_start; pe = frame_end;
      @(negedge clk);
      cyc++;
    end
    cw_valid = 1'b0;
    check("run_len", n_got, nwant);
  endtask

  initial begin
    int accepts;
    int idle_valid;
    rst = 1'b1; cw_valid = 1'b0; bit_ready = 1'b0; cw_in = '0;
    repeat (2) @(negedge clk);
    check("rst_bit_valid",   bit_valid,   1'b0);
    check("rst_cw_ready",    cw_ready,    1'b1);
    check("rst_bit_out",     bit_out,     1'b0);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_frame_end",   frame_end,   1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Single frame
    feed = '{CW_A}; feed_at = '{0};
    run(79, -1, 1'b0);
    check("single_frame",  got[78:0], {SW, CW_A});
    check("single_latency", first_valid, 1);
    check("single_flags",  flag_err, 0);
    check("single_gaps",   gaps, 0);
    check("single_idle_valid", bit_valid, 1'b0);
    check("single_idle_ready", cw_ready, 1'b1);

    // Back-to-back
    feed = '{CW_B, CW_C}; feed_at = '{0, 0};
    run(158, -1, 1'b0);
    check("b2b_frames",   got, {SW, CW_B, SW, CW_C});
    check("b2b_n_acc",    acc_cyc.size(), 2);
    check("b2b_acc2_cyc", acc_cyc[1], 1);
    check("b2b_ready_low", ready_low, 78);
    check("b2b_gaps",     gaps, 0);
    check("b2b_flags",    flag_err, 0);

    // Backpressure: 10-cycle stall at data bit 40, then random ready
    feed = '{CW_D}; feed_at = '{0};
    run(79, 56, 1'b1);
    check("bp_frame",  got[78:0], {SW, CW_D});
    check("bp_stable", stall_err, 0);
    check("bp_flags",  flag_err, 0);

    // Accept on the same edge as the last data bit
    feed = '{CW_E, CW_F}; feed_at = '{0, 79};
    run(158, -1, 1'b0);
    check("edge_frames",   got, {SW, CW_E, SW, CW_F});
    check("edge_acc2_cyc", acc_cyc[1], 79);
    check("edge_gaps",     gaps, 0);
    check("edge_ready_low", ready_low, 0);
    check("edge_flags",    flag_err, 0);

    // Reset at data bit 30 with hold occupied
    feed = '{CW_G, CW_H}; feed_at = '{0, 0};
    run(46, -1, 1'b0);
    check("mid_hold_full", cw_ready, 1'b0);
    check("mid_valid",     bit_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", bit_valid, 1'b0);
    check("mid_rst_ready", cw_ready, 1'b1);
    feed = '{CW_J}; feed_at = '{0};
    run(79, -1, 1'b0);
    check("mid_new_frame",  got[78:0], {SW, CW_J});
    check("mid_new_latency", first_valid, 1);
    check("mid_new_gaps",   gaps, 0);
    idle_valid = 0;
    repeat (5) begin
      if (bit_valid !== 1'b0) idle_valid++;
      @(negedge clk);
    end
    check("mid_no_resume", idle_valid, 0);

    // Full buffer: cw_valid held for 200 cycles with no bit_ready
    bit_ready = 1'b0;
    accepts = 0;
    kept.delete();
    for (int i = 0; i < 200; i++) begin
      cw_valid = 1'b1;
      cw_in    = {47'h1234_5678_9ABC, 16'(i)};
      if (cw_ready === 1'b1) begin
        accepts++;
        kept.push_back(cw_in);
      end
      @(negedge clk);
    end
    cw_valid = 1'b0;
    check("full_accepts", accepts, 2);
    check("full_ready",   cw_ready, 1'b0);
    feed.delete(); feed_at.delete();
    run(158, -1, 1'b0);
    check("full_drain", got, {SW, kept[0], SW, kept[1]});
    check("full_drain_gaps", gaps, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bch_frame_serializer.md
# bch_frame_serializer

Downstream stage of `bch_encoder`. It accepts complete 63-bit BCH(63,51) codewords in parallel and double-buffers them. Each codeword goes out as a serial frame: a fixed sync word followed by the codeword, MSB first, over a valid/ready bit stream toward the modulator. With continuous input and no backpressure, frames leave back-to-back with no idle bits.

## Interface
Parameters:
- `CW_LEN`, 63, codeword length in bits.
- `SYNC_LEN`, 16, sync header length in bits.
- `SYNC_WORD`, 16'hEB90, sync pattern; its MSB is sent first.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cw_in` in CW_LEN: codeword from `bch_encoder`. Bits [62:12] are the message and bits [11:0] are parity.
- `cw_valid` in 1: `cw_in` is valid in this cycle.
- `cw_ready` out 1: the block can accept a codeword in this cycle.
- `bit_out` out 1: serial data.
- `bit_valid` out 1: `bit_out` is valid.
- `bit_ready` in 1: the downstream consumer takes `bit_out` this cycle.
- `frame_start` out 1: high together with the first sync bit.
- `frame_end` out 1: high together with `cw_in[0]` of the frame.

## Operation
- Accept event: `cw_valid && cw_ready` at a rising edge.
- Bit transfer event: `bit_valid && bit_ready` at a rising edge.
- Storage:
  - `shreg`: the active frame register.
  - `hold`: one holding register for the next codeword, with a `hold_full` flag.
  - `cw_ready = !hold_full`. It is driven from a register, with no combinational path from `cw_valid`.
- States:
  - IDLE: `bit_valid=0`.
  - SYNC: bits `SYNC_WORD[15..0]` are sent.
  - DATA: bits `cw[62..0]` are sent.
- Bit counter `cnt` is 7 bits wide. It is cleared on load and incremented on each bit transfer. SYNC ends when `cnt==SYNC_LEN-1` transfers; DATA ends when `cnt==CW_LEN-1` transfers.
- IDLE + accept: load `cw_in` directly into `shreg`, go to SYNC, set `cnt=0`. `hold` stays empty.
- SYNC/DATA + accept: write `cw_in` into `hold` and set `hold_full=1`.
- SYNC: `bit_out = SYNC_WORD[SYNC_LEN-1-cnt]`. On the transfer of the last sync bit, go to DATA with `cnt=0`.
- DATA: `bit_out = shreg[CW_LEN-1-cnt]`, implemented as a left-shift register or an index; either is allowed.
- On the transfer of the last DATA bit:
  - If `hold_full`: move `hold` into `shreg`, clear `hold_full`, go to SYNC.
  - Else if an accept happens in the same cycle: load `cw_in` directly into `shreg` and go to SYNC. Because `hold` is empty, `cw_ready` is 1 in this case.
  - Otherwise: go to IDLE.
- Backpressure: while `bit_valid && !bit_ready`, hold `bit_out`, `frame_start`, `frame_end`, the state and `cnt` stable.
- `frame_start = (state==SYNC && cnt==0)`; `frame_end = (state==DATA && cnt==CW_LEN-1)`.
- A codeword is never dropped or duplicated. At most two codewords are held in the block: one in `shreg` and one in `hold`.

## Timing
- Reset values (one edge with `rst=1`): state IDLE, `cnt=0`, `hold_full=0`, `bit_out=0`, `bit_valid=0`, `frame_start=0`, `frame_end=0`, `cw_ready=1`.
- Reset mid-frame discards both the current frame and `hold`. No partial frame resumes afterwards.
- Latency: if a codeword is accepted at edge N in IDLE, the first sync bit is valid after edge N, with `bit_valid=1` and `frame_start=1`.
- Frame length is `SYNC_LEN+CW_LEN` = 79 bit transfers.
- Throughput: with `bit_ready=1` and a codeword always pending, one bit is sent per cycle and consecutive frames have no gap.
- `cw_ready` falls on the edge after `hold` is filled. It rises on the edge where `hold` moves into `shreg`.

## Structure
- The shared package `bch_pkg` holds:
  - `CW_LEN=63`, `MSG_LEN=51`, `PAR_LEN=12`, `SYNC_WORD=16'hEB90`.
  - typedef `ser_state_t` enum {IDLE, SYNC, DATA}.
- No sub-module: the holding register, counter and FSM live inline in one module.

## Test plan
- Single frame: after reset, accept `cw_in=63'h2AAA_AAAA_AAAA_AAAA` with `bit_ready=1`.
  - Expect 16 sync bits `1110101110010000`, then `0101…` for 63 bits.
  - `frame_start` is high at bit 0 and `frame_end` at bit 78; `bit_valid=0` afterwards.
- Back-to-back: present codewords `63'h7FFF_FFFF_FFFF_F000` and `63'h0000_0000_0000_0FFF` continuously.
  - The second is accepted one cycle after the first.
  - `cw_ready=0` until the first frame's last bit.
  - Expect 158 contiguous valid bits with no gap.
- Backpressure: hold `bit_ready=0` for 10 cycles at data bit 40, then randomize it at 50%.
  - `bit_out` and the flags stay stable while stalled.
  - The reassembled codeword equals the input.
- Boundary at frame end: `hold` is empty and a new codeword is accepted on the same edge as the last DATA bit.
  - The next `frame_start` appears on the following cycle.
- Reset mid-frame: assert `rst` at data bit 30 while `hold_full=1`.
  - The next cycle shows `bit_valid=0`, `cw_ready=1`.
  - A new codeword then produces a fresh complete 79-bit frame, and neither of the old codewords is emitted.
- Full buffer: keep `cw_valid=1` for 200 cycles with `bit_ready=0`.
  - Exactly 2 codewords are accepted and `cw_ready` stays 0 after that.
